// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the ALU. Shift-add multiply and restoring
// divide run on operand magnitudes, one bit per cycle, then sign-correct into HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  // Per-operation context latched at accept; only the running op reads it.
  typedef struct packed {
    logic             is_div;
    logic             neg_lo;   // product / quotient negated
    logic             neg_hi;   // remainder negated (dividend sign)
    logic             dbz;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  } ctx_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  ctx_t               ctx, ctx_d;
  logic [2*WIDTH:0]   acc, acc_n;
  logic               accept, last;

  logic               sa, sb;
  logic [WIDTH-1:0]   amag, bmag;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_mag, r_mag, res_hi, res_lo;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

  // Operand capture: magnitudes for signed ops; 0x80.. stays 0x80.. as unsigned.
  always_comb begin
    sa            = op[0] & a[WIDTH-1];
    sb            = op[0] & b[WIDTH-1];
    amag          = sa ? -a : a;
    bmag          = sb ? -b : b;
    ctx_d.is_div  = op[1];
    ctx_d.neg_lo  = sa ^ sb;
    ctx_d.neg_hi  = sa;
    ctx_d.dbz     = op[1] && (b == '0);
    ctx_d.a_raw   = a;
    ctx_d.opnd    = op[1] ? bmag : amag;
  end

  // One iteration. acc = {upper(W+1), lower(W)}: product/multiplier for multiply,
  // remainder/quotient for divide.
  always_comb begin
    mul_sum = acc[2*WIDTH:WIDTH] + {1'b0, ctx.opnd};
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, rem_sh} - {2'b0, ctx.opnd};
    if (ctx.is_div)
      acc_n = diff[WIDTH+1] ? {rem_sh, acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    else if (acc[0])
      acc_n = {mul_sum, acc[WIDTH-1:0]} >> 1;
    else
      acc_n = acc >> 1;
  end

  // Sign correction on the value produced by the final iteration.
  always_comb begin
    prod  = ctx.neg_lo ? -acc_n[2*WIDTH-1:0] : acc_n[2*WIDTH-1:0];
    q_mag = acc_n[WIDTH-1:0];
    r_mag = acc_n[2*WIDTH-1:WIDTH];
    if (!ctx.is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (ctx.dbz) begin
      res_hi = ctx.a_raw;
      res_lo = '1;
    end else begin
      res_hi = ctx.neg_hi ? -r_mag : r_mag;
      res_lo = ctx.neg_lo ? -q_mag : q_mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      ctx         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      ctx <= ctx_d;
      acc <= {{(WIDTH+1){1'b0}}, (op[1] ? amag : bmag)};
    end else if (state == S_RUN) begin
      acc <= acc_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        hi          <= res_hi;
        lo          <= res_lo;
        div_by_zero <= ctx.dbz;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (last)  state_n = S_DONE;
      S_DONE:  state_n = start ? S_RUN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/div_by_zero queued at issue,
// popped and compared when done pulses.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk, rst_n, start;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_by_zero;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        r;
    longint      sx, sy, q, m;
    logic [63:0] p;
    sx    = o[0] ? longint'($signed(x)) : longint'({32'b0, x});
    sy    = o[0] ? longint'($signed(y)) : longint'({32'b0, y});
    r.dbz = 1'b0;
    if (!o[1]) begin
      p    = sx * sy;
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (y == '0) begin
      r.hi  = x;
      r.lo  = '1;
      r.dbz = 1'b1;
    end else begin
      q    = sx / sy;
      m    = sx % sy;
      r.hi = m[31:0];
      r.lo = q[31:0];
    end
    return r;
  endfunction

  // Drive a one-cycle start; returns at the first sample of the run.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count run cycles until done (bounded); flags any hi/lo change or busy drop.
  task automatic wait_done(output int lat, output bit stable);
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo; lat = 1; stable = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (hi !== h0 || lo !== l0 || busy !== 1'b1) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b hi=%h lo=%h dbz=%b want all 0", busy, done, hi, lo, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_multiply();
    logic [1:0]   vo[6];
    logic [W-1:0] va[6], vb[6], eh[4], el[4];
    exp_t e;
    int   lat;
    bit   stb;
    vo = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h12345678, 32'h0};
    vb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'h80000000, 32'h9ABCDEF0, 32'h0};
    eh = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h40000000};
    el = '{32'h00000001, 32'h00000001, 32'hFFFFFFEB, 32'h00000000};
    va[5] = $urandom; vb[5] = $urandom;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) e = '{eh[i], el[i], 1'b0};
      else       e = model(vo[i], va[i], vb[i]);
      issue(vo[i], va[i], vb[i], e);
      wait_done(lat, stb);
      e = sb.pop_front();
      checks++;
      if ({hi, lo, div_by_zero} !== e) begin
        errors++;
        $display("FAIL mul_result[%0d] got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
      end
      checks++;
      if (lat != W + 1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_latency[%0d] got %0d cycles busy=%b want %0d busy=0", i, lat, busy, W + 1);
      end
      checks++;
      if (!stb) begin
        errors++;
        $display("FAIL mul_run_stable[%0d] got hi/lo/busy disturbed in run want held", i);
      end
    end
  endtask

  task automatic test_divide();
    logic [1:0]   vo[7];
    logic [W-1:0] va[7], vb[7], eh[5], el[5];
    exp_t e;
    int   lat;
    bit   stb;
    vo = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2};
    va = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7, 32'd5, 32'h0, 32'h0};
    vb = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd9, 32'h0, 32'h0};
    eh = '{32'hFFFFFFFF, 32'd2, 32'h0, 32'd1, 32'd5};
    el = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFD, 32'd0};
    va[5] = $urandom; vb[5] = $urandom_range(1, 32'hFFFF);
    va[6] = $urandom; vb[6] = $urandom | 32'h1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) e = '{eh[i], el[i], 1'b0};
      else       e = model(vo[i], va[i], vb[i]);
      issue(vo[i], va[i], vb[i], e);
      wait_done(lat, stb);
      e = sb.pop_front();
      checks++;
      if ({hi, lo, div_by_zero} !== e) begin
        errors++;
        $display("FAIL div_result[%0d] got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
      end
      checks++;
      if (lat != W + 1 || !stb) begin
        errors++;
        $display("FAIL div_timing[%0d] got %0d cycles stable=%b want %0d stable=1", i, lat, stb, W + 1);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [1:0]   vo[4];
    logic [W-1:0] va[4], vb[4], eh[4], el[4];
    logic         ed[4];
    exp_t e;
    int   lat;
    bit   stb;
    vo = '{2'd2, 2'd0, 2'd3, 2'd3};
    va = '{32'h1234, 32'd3, 32'hFFFFFFFB, 32'd9};
    vb = '{32'h0, 32'd5, 32'h0, 32'd3};
    eh = '{32'h1234, 32'h0, 32'hFFFFFFFB, 32'h0};
    el = '{32'hFFFFFFFF, 32'd15, 32'hFFFFFFFF, 32'd3};
    ed = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(vo[i], va[i], vb[i], '{eh[i], el[i], ed[i]});
      wait_done(lat, stb);
      e = sb.pop_front();
      checks++;
      if ({hi, lo, div_by_zero} !== e || lat != W + 1) begin
        errors++;
        $display("FAIL dbz[%0d] got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d",
                 i, hi, lo, div_by_zero, lat, e.hi, e.lo, e.dbz, W + 1);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   lat;
    bit   stb;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'hDEADBEEF; b = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run got busy=%b done=%b hi=%h lo=%h dbz=%b want all 0", busy, done, hi, lo, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd0, 32'h00010000, 32'h00030000, '{32'h3, 32'h0, 1'b0});
    wait_done(lat, stb);
    e = sb.pop_front();
    checks++;
    if ({hi, lo, div_by_zero} !== e || lat != W + 1) begin
      errors++;
      $display("FAIL reset_recover got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d", hi, lo, lat, e.hi, e.lo, W + 1);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   lat;
    issue(2'd0, 32'h12345678, 32'h9ABCDEF0, model(2'd0, 32'h12345678, 32'h9ABCDEF0));
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 5) begin
        start = 1'b1; op = 2'd3; a = 32'h55; b = 32'h0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({hi, lo, div_by_zero} !== e || lat != W + 1) begin
      errors++;
      $display("FAIL ignore_start got hi=%h lo=%h dbz=%b lat=%0d want hi=%h lo=%h dbz=%b lat=%0d",
               hi, lo, div_by_zero, lat, e.hi, e.lo, e.dbz, W + 1);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   stb;
    issue(2'd1, 32'hFFFFFFF9, 32'd3, '{32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    wait_done(lat, stb);
    e = sb.pop_front();
    checks++;
    if ({hi, lo, div_by_zero} !== e || lat != W + 1) begin
      errors++;
      $display("FAIL b2b_first got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d", hi, lo, lat, e.hi, e.lo, W + 1);
    end
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    sb.push_back('{32'd2, 32'd14, 1'b0});
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(lat, stb);
    e = sb.pop_front();
    checks++;
    if ({hi, lo, div_by_zero} !== e || lat != W + 1 || !stb) begin
      errors++;
      $display("FAIL b2b_second got hi=%h lo=%h lat=%0d stable=%b want hi=%h lo=%h lat=%0d stable=1",
               hi, lo, lat, stb, e.hi, e.lo, W + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_reset_mid_run();
    test_ignore_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
